frame_buffer: RTL and testbench

Pixel source that feeds the VGA timing stage: holds a 160×120 image of 6-bit pixels (2 bits each R, G, B), scaled 4× in both axes to fill 640×480. It looks up the pixel at the VGA stage's current `x`/`y` and drives that stage's `R`/`G`/`B` inputs. It also accepts single-pixel writes from game logic through a valid/ready handshake, and runs a full-screen clear sequence on request and after reset.

---
 rtl/frame_buffer.sv | 111 +++++++++++
 tb/tb_frame_buffer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/frame_buffer.sv
// 160x120x6 framebuffer scaled 4x onto the VGA raster: 3-stage read pipeline
// plus a single-pixel write port and a full-screen clear sequencer.
module frame_buffer #(
  parameter int          FB_W        = 160,
  parameter int          FB_H        = 120,
  parameter logic [5:0]  CLEAR_COLOR = 6'b000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       active,
  output logic [1:0] R,
  output logic [1:0] G,
  output logic [1:0] B,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  logic [5:0] wr_color,
  input  logic       clear_req,
  output logic       busy
);
  localparam int         DEPTH = FB_W * FB_H;
  localparam logic [14:0] LAST = 15'(DEPTH - 1);
  localparam logic [7:0]  W8   = 8'(FB_W);
  localparam logic [6:0]  H7   = 7'(FB_H);

  typedef enum logic {IDLE, CLEAR} state_t;

  // row*160 + col as two shifts and a 15-bit add
  function automatic logic [14:0] fb_addr(input logic [7:0] row, input logic [7:0] col);
    return ({7'd0, row} << 7) + ({7'd0, row} << 5) + {7'd0, col};
  endfunction

  logic [5:0]  mem [DEPTH];

  state_t      state_q, state_d;
  logic [14:0] clr_cnt_q, clr_cnt_d;
  logic        we;
  logic [14:0] waddr;
  logic [5:0]  wdata;

  logic [14:0] rd_addr_q;
  logic [1:0]  vis_pipe_q;
  logic [5:0]  rdata_q;
  logic [5:0]  rgb_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    we        = 1'b0;
    waddr     = fb_addr({1'b0, wr_y}, wr_x);
    wdata     = wr_color;
    case (state_q)
      IDLE: begin
        we = wr_valid && (wr_x < W8) && (wr_y < H7);
        if (clear_req) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt_q;
        wdata = CLEAR_COLOR;
        if (clr_cnt_q == LAST) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 15'd1;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign wr_ready = (state_q == IDLE);
  assign busy     = (state_q == CLEAR);

  // Invisible coordinates read address 0 so wrapped addresses never index memory
  always_ff @(posedge CLOCK_50) begin
    if (we && reset) mem[waddr] <= wdata;
    rdata_q <= mem[vis_pipe_q[0] ? rd_addr_q : 15'd0];
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      rd_addr_q  <= '0;
      vis_pipe_q <= '0;
      rgb_q      <= '0;
    end else begin
      rd_addr_q     <= fb_addr(y[9:2], x[9:2]);
      vis_pipe_q[0] <= active && (x < 10'd640) && (y < 10'd480);
      vis_pipe_q[1] <= vis_pipe_q[0];
      rgb_q         <= vis_pipe_q[1] ? rdata_q : 6'd0;
    end
  end

  assign {R, G, B} = rgb_q;
endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer: clear timing, write/read path, clipping, clear restart.
module tb_frame_buffer;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       active;
  logic [1:0] R, G, B;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [5:0] wr_color;
  logic       clear_req, busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] exp_mem [19200];

  frame_buffer dut (
    .CLOCK_50(clk), .reset(reset), .x(x), .y(y), .active(active),
    .R(R), .G(G), .B(B), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .clear_req(clear_req), .busy(busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int rgb();
    return int'({R, G, B});
  endfunction

  // Ticks until busy drops; returns the number of ticks taken (bounded)
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 25000) begin
      tick();
      n++;
    end
  endtask

  task automatic rd(input int px, input int py, input logic act, input string tag, input int exp);
    x = 10'(px); y = 10'(py); active = act;
    tick(3);
    chk(tag, rgb(), exp);
  endtask

  // One framebuffer pixel per cycle; output lags the drive by three edges
  task automatic scan(output int diffs);
    diffs = 0;
    for (int i = 0; i < 19202; i++) begin
      if (i < 19200) begin
        x = 10'((i % 160) * 4); y = 10'((i / 160) * 4); active = 1'b1;
      end else begin
        x = 10'd1023; y = 10'd1023; active = 1'b0;
      end
      tick();
      if (i >= 2 && rgb() != int'(exp_mem[i-2])) diffs++;
    end
  endtask

  initial begin
    int n;
    reset = 1'b0; x = '0; y = '0; active = 1'b0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0; clear_req = 1'b0;
    for (int i = 0; i < 19200; i++) exp_mem[i] = 6'd0;

    tick(2);
    chk("rst_busy", busy, 1);
    chk("rst_ready", wr_ready, 0);
    chk("rst_rgb", rgb(), 0);

    reset = 1'b1;
    count_busy(n);
    chk("clr_len", n, 19200);
    chk("clr_ready", wr_ready, 1);

    // Pixel (10,5) = 110110 -> R=3 G=1 B=2
    wr_valid = 1'b1; wr_x = 8'd10; wr_y = 7'd5; wr_color = 6'b110110;
    chk("wr_rdy", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    exp_mem[5*160+10] = 6'b110110;

    rd(0, 0, 1'b1, "blk00", 0);
    x = 10'd40; y = 10'd20; active = 1'b1;
    tick(2);
    chk("lat2", rgb(), 0);
    tick();
    chk("px_R", R, 3);
    chk("px_G", G, 1);
    chk("px_B", B, 2);
    rd(43, 23, 1'b1, "px_4323", 54);
    rd(44, 20, 1'b1, "px_44", 0);

    // Write and read of the same pixel entering S0 on the same edge
    wr_valid = 1'b1; wr_x = 8'd11; wr_y = 7'd5; wr_color = 6'b100111;
    x = 10'd44; y = 10'd20; active = 1'b1;
    tick();
    wr_valid = 1'b0;
    exp_mem[5*160+11] = 6'b100111;
    tick(2);
    chk("wr2rd", rgb(), 39);

    rd(40, 20, 1'b0, "inact", 0);
    rd(1023, 20, 1'b1, "x1023", 0);
    rd(40, 1023, 1'b1, "y1023", 0);

    // Out-of-range writes complete the handshake but touch nothing
    wr_valid = 1'b1; wr_x = 8'd160; wr_y = 7'd0; wr_color = 6'b111111;
    chk("oor_x_rdy", wr_ready, 1);
    tick();
    wr_x = 8'd0; wr_y = 7'd120; wr_color = 6'b010101;
    chk("oor_y_rdy", wr_ready, 1);
    tick();
    wr_x = 8'd255; wr_y = 7'd127; wr_color = 6'b001100;
    tick();
    wr_valid = 1'b0;
    scan(n);
    chk("scan", n, 0);

    // Clear request together with a write to (0,0)
    wr_valid = 1'b1; wr_x = 8'd0; wr_y = 7'd0; wr_color = 6'b111111; clear_req = 1'b1;
    chk("cq_rdy", wr_ready, 1);
    tick();
    wr_valid = 1'b0; clear_req = 1'b0;
    chk("cq_busy", busy, 1);
    chk("cq_ready", wr_ready, 0);

    // Restart mid-clear at clr_cnt = 5000
    tick(5000);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_busy", busy, 1);
    chk("mid_rgb", rgb(), 0);
    count_busy(n);
    chk("mid_len", n, 19200);
    chk("mid_ready", wr_ready, 1);
    rd(0, 0, 1'b1, "clr00", 0);
    rd(40, 20, 1'b1, "clr105", 0);
    rd(44, 20, 1'b1, "clr115", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
